// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_pkg
// Description : Shared md_op encodings, FSM state type and default latencies
//               for the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11,
        MD_MSUBU = 4'd12
    } md_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;
    localparam int CNT_W       = 8;

endpackage
`default_nettype wire

// File: rtl/md_div_core.sv
`default_nettype none
// ============================================================================
// Module      : md_div_core
// Description : Combinational signed/unsigned 32-bit divide with quotient,
//               remainder, divide-by-zero flag and INT_MIN / -1 handling.
// Revision    : 1.0 - initial release
// ============================================================================
module md_div_core (
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_zero
);

    logic        neg_a;
    logic        neg_b;
    logic        ovf;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;

    // Divide magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend.
    always_comb begin
        neg_a    = is_signed & dividend[31];
        neg_b    = is_signed & divisor[31];
        mag_a    = neg_a ? (32'd0 - dividend) : dividend;
        mag_b    = neg_b ? (32'd0 - divisor)  : divisor;
        div_zero = (divisor == 32'd0);
        ovf      = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
        uq       = 32'd0;
        ur       = 32'd0;
        quot     = 32'd0;
        rem      = 32'd0;
        if (div_zero) begin
            quot = 32'd0;
            rem  = 32'd0;
        end else if (ovf) begin
            quot = 32'h8000_0000;
            rem  = 32'd0;
        end else begin
            uq   = mag_a / mag_b;
            ur   = mag_a % mag_b;
            quot = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
            rem  = neg_a ? (32'd0 - ur) : ur;
        end
    end

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : E-stage multi-cycle multiply/divide unit holding HI/LO.
//               Define MD_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit
    import md_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rd
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [63:0]      pend_q, pend_d;

    md_op_e      op;
    logic        is_mul, is_div, is_acc, is_sub, is_sgn;
    logic        take, launch;
    logic [63:0] prod, mul_res, issue_res;
    logic [31:0] quot, rem;
    logic        div_zero;

    assign op = md_op_e'(md_op);

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        is_acc = 1'b0;
        is_sub = 1'b0;
        is_sgn = 1'b0;
        case (op)
            MD_MULT:  begin is_mul = 1'b1; is_sgn = 1'b1; end
            MD_MULTU: is_mul = 1'b1;
            MD_DIV:   begin is_div = 1'b1; is_sgn = 1'b1; end
            MD_DIVU:  is_div = 1'b1;
`ifdef MD_MADD_EN
            MD_MADD:  begin is_mul = 1'b1; is_acc = 1'b1; is_sgn = 1'b1; end
            MD_MADDU: begin is_mul = 1'b1; is_acc = 1'b1; end
            MD_MSUB:  begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; is_sgn = 1'b1; end
            MD_MSUBU: begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
            default:  ;
        endcase
    end

    assign take   = start && !flush && (state_q == ST_IDLE);
    assign launch = take && (is_mul || is_div);

    md_div_core u_div (
        .dividend  (a),
        .divisor   (b),
        .is_signed (is_sgn),
        .quot      (quot),
        .rem       (rem),
        .div_zero  (div_zero)
    );

    // Low 64 bits of the product are the same whether the operands are
    // treated as signed or unsigned once extended to 64 bits.
    always_comb begin
        if (is_sgn) begin
            prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        end else begin
            prod = {32'd0, a} * {32'd0, b};
        end
        mul_res = prod;
        if (is_acc) begin
            mul_res = is_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
        end
        if (is_div) begin
            issue_res = div_zero ? {hi_q, lo_q} : {rem, quot};
        end else begin
            issue_res = mul_res;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (launch) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        pend_d = pend_q;
        if (state_q == ST_RUN) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                {hi_d, lo_d} = pend_q;
            end
        end else if (launch) begin
            cnt_d  = is_div ? DIV_CNT : MUL_CNT;
            pend_d = issue_res;
        end else if (take && (op == MD_MTHI)) begin
            hi_d = a;
        end else if (take && (op == MD_MTLO)) begin
            lo_d = a;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        busy  = (state_q == ST_RUN);
        hi    = hi_q;
        lo    = lo_q;
        md_rd = 32'd0;
        if (op == MD_MFHI) md_rd = hi_q;
        else if (op == MD_MFLO) md_rd = lo_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit
// Description : Self-checking bench for md_unit against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;
    import md_pkg::*;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_rd;

    always #5 clk = ~clk;

    md_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo),
        .md_rd (md_rd)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Architectural effect of one accepted op on the model HI/LO; returns busy length.
    task automatic model(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         output int lat);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     hl;
        sa  = longint'($signed(av));
        sb  = longint'($signed(bv));
        ua  = 64'(av);
        ub  = 64'(bv);
        hl  = {m_hi, m_lo};
        lat = 0;
        case (md_op_e'(op))
            MD_MULT:  begin hl = 64'(sa * sb); lat = MUL_LAT; end
            MD_MULTU: begin hl = 64'(ua * ub); lat = MUL_LAT; end
            MD_DIV: begin
                lat = DIV_LAT;
                if (bv != 32'd0) begin
                    q  = sa / sb;
                    r  = sa % sb;
                    hl = {r[31:0], q[31:0]};
                end
            end
            MD_DIVU: begin
                lat = DIV_LAT;
                if (bv != 32'd0) begin
                    uq = ua / ub;
                    ur = ua % ub;
                    hl = {ur[31:0], uq[31:0]};
                end
            end
            MD_MTHI: hl[63:32] = av;
            MD_MTLO: hl[31:0]  = av;
`ifdef MD_MADD_EN
            MD_MADD:  begin hl = hl + 64'(sa * sb); lat = MUL_LAT; end
            MD_MADDU: begin hl = hl + 64'(ua * ub); lat = MUL_LAT; end
            MD_MSUB:  begin hl = hl - 64'(sa * sb); lat = MUL_LAT; end
            MD_MSUBU: begin hl = hl - 64'(ua * ub); lat = MUL_LAT; end
`endif
            default: ;
        endcase
        {m_hi, m_lo} = hl;
    endtask

    // mid: 0 = quiet, 1 = flush in busy cycle 2, 2 = illegal start in busy cycle 2
    task automatic do_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input bit fl, input int mid);
        int          lat;
        int          cyc;
        logic [31:0] old_hi, old_lo;
        old_hi = m_hi;
        old_lo = m_lo;
        lat    = 0;
        if (!fl) model(op, av, bv, lat);
        md_op = op; a = av; b = bv; start = 1'b1; flush = fl;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0; md_op = MD_NONE; a = $urandom; b = $urandom;
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            if (cyc == 1) begin
                check("hold_hi", 64'(hi), 64'(old_hi));
                check("hold_lo", 64'(lo), 64'(old_lo));
            end
            if (cyc == 2 && mid == 1) flush = 1'b1;
            if (cyc == 2 && mid == 2) begin
                start = 1'b1;
                md_op = $urandom_range(0, 1) ? MD_MTLO : MD_MULT;
            end
            @(posedge clk); #1;
            start = 1'b0; flush = 1'b0; md_op = MD_NONE;
        end
        check("busy_cycles", 64'(cyc), 64'(lat));
        check("hi", 64'(hi), 64'(m_hi));
        check("lo", 64'(lo), 64'(m_lo));
        md_op = MD_MFHI; #1;
        check("mfhi", 64'(md_rd), 64'(m_hi));
        md_op = MD_MFLO; #1;
        check("mflo", 64'(md_rd), 64'(m_lo));
        md_op = MD_NONE; #1;
        check("rd_none", 64'(md_rd), 64'd0);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        clr = 1'b0; start = 1'b0; flush = 1'b0; md_op = MD_NONE; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        clr = 1'b1;
        @(posedge clk); #1;

        do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 0);
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo), 64'hFFFF_FFFA);
        do_op(MD_DIVU, 32'd100, 32'd7, 1'b0, 0);
        check("divu_lo", 64'(lo), 64'd14);
        check("divu_hi", 64'(hi), 64'd2);
        do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        check("div_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(hi), 64'hFFFF_FFFF);
        do_op(MD_MTHI, 32'h1234, 32'd0, 1'b0, 0);
        do_op(MD_DIV, 32'd5, 32'd0, 1'b0, 0);
        check("div0_hi", 64'(hi), 64'h1234);
        check("div0_lo", 64'(lo), 64'hFFFF_FFFD);
        do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        check("ovf_lo", 64'(lo), 64'h8000_0000);
        check("ovf_hi", 64'(hi), 64'd0);
        do_op(MD_MULT, 32'd3, 32'd4, 1'b1, 0);
        do_op(MD_MULT, 32'd3, 32'd4, 1'b0, 1);
        check("flush_mid_lo", 64'(lo), 64'd12);
        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2);

        do_op(MD_MTHI, 32'd0, 32'd0, 1'b0, 0);
        do_op(MD_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
        do_op(MD_MADDU, 32'd1, 32'd1, 1'b0, 0);
`ifdef MD_MADD_EN
        check("maddu_hi", 64'(hi), 64'd1);
        check("maddu_lo", 64'(lo), 64'd0);
`else
        check("maddu_off_hi", 64'(hi), 64'd0);
        check("maddu_off_lo", 64'(lo), 64'hFFFF_FFFF);
`endif

        // Asynchronous reset between edges while a multiply is running
        do_op(MD_MTLO, 32'h5555_AAAA, 32'd0, 1'b0, 0);
        md_op = MD_MULT; a = 32'd3; b = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; md_op = MD_NONE;
        @(posedge clk); #2;
        clr = 1'b0; #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        md_op = MD_MFLO; #1;
        check("arst_mflo", 64'(md_rd), 64'd0);
        md_op = MD_NONE; clr = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        @(posedge clk); #1;

        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 12));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            do_op(rop, ra, rb, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the pipelined MIPS CPU.
- Executes MULT/MULTU/DIV/DIVU over several cycles and holds the HI/LO architectural registers.
- Serves MFHI/MFLO reads; the read value is routed into the E-stage ALU-output mux feeding the E/M pipe register.
- Drives busy so the hazard unit can stall dependent md instructions in D.

Parameters:
- MUL_LAT, 5, cycles busy stays high after an accepted MULT/MULTU.
- DIV_LAT, 10, cycles busy stays high after an accepted DIV/DIVU.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous, active-low reset.
- start  in  1  E-stage instruction is a multiply/divide op; valid for one cycle.
- md_op  in  4  operation code from the shared package.
- a  in  32  rs value, already forwarded.
- b  in  32  rt value, already forwarded.
- flush  in  1  exception/interrupt taken in M this cycle; cancels the E-stage instruction.
- busy  out  1  operation in progress.
- hi  out  32  HI register.
- lo  out  32  LO register.
- md_rd  out  32  MFHI→hi, MFLO→lo, otherwise 0; combinational from md_op.

Behaviour:
- Reset (clr=0, async): hi=0, lo=0, busy=0, counter=0, pending results=0, state IDLE.
- States:
  - IDLE → RUN on an accepted MULT/MULTU/DIV/DIVU. Load the counter with MUL_LAT or DIV_LAT. Capture the 64-bit result in pending registers at issue.
  - RUN: counter decrements each cycle. busy=1 for exactly LAT cycles, starting the cycle after acceptance.
  - RUN → IDLE on the cycle the counter reads 1. hi/lo take pending {hi,lo} at that same edge, so busy falls and new hi/lo are visible together.
- Accept condition: start=1 && flush=0 && busy=0.
  - start with flush=1: no effect at all (cancelled instruction).
  - start while busy=1: ignored. This is a protocol violation; the hazard unit prevents it, and the bench asserts it has no effect.
- Flush while in RUN does not abort. The instruction is older than the faulting one and has committed.
- MTHI/MTLO, accepted only in IDLE: write a into hi or lo at the next edge. No busy; the other register is unchanged.
- Arithmetic:
  - MULT: signed 32×32 product, {hi,lo}=product[63:0].
  - MULTU: unsigned 32×32 product.
  - DIV/DIVU: lo=quotient, hi=remainder, signed or unsigned as named.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divisor 0: hi/lo unchanged, but busy still runs DIV_LAT cycles.
  - 0x80000000 / -1 (signed): lo=0x80000000, hi=0.
- md_rd is valid only when busy=0. The hazard unit stalls MFHI/MFLO while busy or start.

Optional Feature:
- Macro MD_MADD_EN.
- Defined: adds MADD, MADDU, MSUB, MSUBU codes.
  - {hi,lo} ± 64-bit product (signed/unsigned), wrapping modulo 2^64.
  - Latency is MUL_LAT; the accumulation uses the hi/lo value at issue.
- Undefined: those codes decode as no-op; no state change, no busy.

Decomposition:
- Shared package md_pkg holds:
  - md_op encodings: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO, MADD, MADDU, MSUB, MSUBU.
  - Default latency constants.
- One sub-module: md_div_core, a combinational signed/unsigned quotient/remainder with a divide-by-zero flag and the overflow-case rule.
- The FSM, counter and HI/LO registers stay in md_unit.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. The busy falling edge coincides with the update.
- DIVU a=100, b=7 → busy 10 cycles; then lo=14, hi=2. DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MTHI a=0x1234 then DIV a=5, b=0 → hi stays 0x1234 after 10 busy cycles; lo unchanged.
- start=1 with flush=1 for MULT 3×4 → busy never rises; hi/lo unchanged. Flush in cycle 2 of an active MULT 3×4 → lo=12 at completion.
- Async reset mid-RUN (clr low between edges) → busy, hi, lo clear immediately; a later MFLO gives md_rd=0.
- MD_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU 1×1 → hi=1, lo=0. Without the macro, the same op leaves hi=0, lo=0xFFFFFFFF and busy=0.
